// File: rtl/ps2_scan_ctrl.sv
// ps2_scan_ctrl: PS/2 scan-code prefix decoder feeding a first-word-fall-through
// event FIFO. Each stored event is {ext, brk, code}; E0 marks an extended key
// and F0 marks a key release.
// Optional feature: define PS2_SCAN_TIMEOUT_EN to abandon a prefix state after
// TIMEOUT_CYC idle cycles, pulsing SEQ_ERR. Without it SEQ_ERR is held at 0.
module ps2_scan_ctrl #(
  parameter int unsigned FIFO_AW     = 2,
  parameter int unsigned TIMEOUT_CYC = 50000
) (
  input  logic               CLOCK,
  input  logic               RESET,
  input  logic [7:0]         RX_DATA,
  input  logic               DATA_VALID,
  output logic [7:0]         KEY_CODE,
  output logic               KEY_EXT,
  output logic               KEY_BREAK,
  output logic               KEY_VALID,
  input  logic               KEY_READY,
  output logic [FIFO_AW:0]   LEVEL,
  output logic               OVERFLOW,
  output logic               SEQ_ERR
);

  localparam int unsigned        DEPTH    = 2 ** FIFO_AW;
  localparam logic [FIFO_AW:0]   LVL_FULL = (FIFO_AW + 1)'(DEPTH);
  localparam logic [FIFO_AW:0]   LVL_ONE  = (FIFO_AW + 1)'(1);
  localparam logic [FIFO_AW-1:0] PTR_ONE  = FIFO_AW'(1);
  localparam logic [7:0]         BYTE_E0  = 8'hE0;
  localparam logic [7:0]         BYTE_F0  = 8'hF0;

  typedef enum logic [1:0] {
    S_IDLE,
    S_EXT,
    S_BRK,
    S_EXT_BRK
  } state_e;

  state_e             state_q, state_d;
  logic               dv_q;
  logic               accept;
  logic               push, push_ext, push_brk;
  logic               do_push, do_pop;

  logic [9:0]         mem_q [DEPTH];
  logic [FIFO_AW-1:0] wr_q, wr_d;
  logic [FIFO_AW-1:0] rd_q, rd_d;
  logic [FIFO_AW:0]   lvl_q, lvl_d;
  logic               ovf_q, ovf_d;

  // Rising edge of the receiver's valid level; dv_q resets high so a level
  // already asserted when reset releases is never taken as a new byte.
  assign accept = DATA_VALID & ~dv_q;

  // Previous DATA_VALID sample for edge detection.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) dv_q <= 1'b1;
    else       dv_q <= DATA_VALID;
  end

`ifdef PS2_SCAN_TIMEOUT_EN
  localparam int unsigned  CW       = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);
  localparam logic [CW-1:0] TMO_ONE  = CW'(1);

  logic [CW-1:0] tmo_q, tmo_d;
  logic          seq_err_q, seq_err_d;
  logic          tmo_hit;

  assign tmo_hit = (state_q != S_IDLE) && (tmo_q == TMO_LAST);

  // Prefix-wait counter: cleared by any accepted byte, runs only in prefix states.
  always_comb begin
    tmo_d = '0;
    if (!accept && state_q != S_IDLE && !tmo_hit) tmo_d = tmo_q + TMO_ONE;
  end

  // Timeout counter and SEQ_ERR pulse register.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      tmo_q     <= '0;
      seq_err_q <= 1'b0;
    end else begin
      tmo_q     <= tmo_d;
      seq_err_q <= seq_err_d;
    end
  end

  assign SEQ_ERR = seq_err_q;
`else
  assign SEQ_ERR = 1'b0;
`endif

  // Decoder next state and event push request.
  always_comb begin
    state_d  = state_q;
    push     = 1'b0;
    push_ext = 1'b0;
    push_brk = 1'b0;
`ifdef PS2_SCAN_TIMEOUT_EN
    seq_err_d = 1'b0;
`endif
    if (accept) begin
      case (state_q)
        S_IDLE: begin
          if (RX_DATA == BYTE_E0)      state_d = S_EXT;
          else if (RX_DATA == BYTE_F0) state_d = S_BRK;
          else                         push    = 1'b1;
        end
        S_EXT: begin
          if (RX_DATA == BYTE_F0)      state_d = S_EXT_BRK;
          else if (RX_DATA != BYTE_E0) begin
            push     = 1'b1;
            push_ext = 1'b1;
            state_d  = S_IDLE;
          end
        end
        S_BRK: begin
          push     = 1'b1;
          push_brk = 1'b1;
          state_d  = S_IDLE;
        end
        S_EXT_BRK: begin
          push     = 1'b1;
          push_ext = 1'b1;
          push_brk = 1'b1;
          state_d  = S_IDLE;
        end
        default: state_d = S_IDLE;
      endcase
    end
`ifdef PS2_SCAN_TIMEOUT_EN
    else if (tmo_hit) begin
      state_d   = S_IDLE;
      seq_err_d = 1'b1;
    end
`endif
  end

  // Decoder state register.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // A push into a full FIFO survives only when a pop frees the slot on the same edge.
  assign do_pop  = (lvl_q != '0) & KEY_READY;
  assign do_push = push & ((lvl_q != LVL_FULL) | do_pop);

  // FIFO pointer, level and sticky overflow next-state.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    lvl_d = lvl_q;
    ovf_d = ovf_q | (push & ~do_push);
    if (do_push) wr_d = wr_q + PTR_ONE;
    if (do_pop)  rd_d = rd_q + PTR_ONE;
    if (do_push && !do_pop)      lvl_d = lvl_q + LVL_ONE;
    else if (!do_push && do_pop) lvl_d = lvl_q - LVL_ONE;
  end

  // FIFO storage and control registers; storage is cleared so outputs read 0 in reset.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      for (int unsigned i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      lvl_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (do_push) mem_q[wr_q] <= {push_ext, push_brk, RX_DATA};
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      lvl_q <= lvl_d;
      ovf_q <= ovf_d;
    end
  end

  assign KEY_EXT   = mem_q[rd_q][9];
  assign KEY_BREAK = mem_q[rd_q][8];
  assign KEY_CODE  = mem_q[rd_q][7:0];
  assign KEY_VALID = (lvl_q != '0);
  assign LEVEL     = lvl_q;
  assign OVERFLOW  = ovf_q;

endmodule

// File: doc/ps2_scan_ctrl.md
PS2_SCAN_CTRL -- requirements
Module: ps2_scan_ctrl

Interface
REQ-001 Parameter FIFO_AW, default 2, log2 of event FIFO depth (depth = 2**FIFO_AW; legal range 1..4).
REQ-002 Parameter TIMEOUT_CYC, default 50000, CLOCK cycles a prefix state may wait before it is abandoned.
REQ-003 CLOCK  input  1  single system clock; all state is updated on its rising edge.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 RX_DATA  input  8  received byte from the PS/2 frame receiver.
REQ-006 DATA_VALID  input  1  level from the receiver; high while RX_DATA holds a checked frame.
REQ-007 KEY_CODE  output  8  scan code of the event at the FIFO head.
REQ-008 KEY_EXT  output  1  head event carried an E0 prefix.
REQ-009 KEY_BREAK  output  1  head event carried an F0 prefix (key release).
REQ-010 KEY_VALID  output  1  FIFO is not empty; head event is presented.
REQ-011 KEY_READY  input  1  consumer accepts the head event.
REQ-012 LEVEL  output  FIFO_AW+1  number of events stored.
REQ-013 OVERFLOW  output  1  sticky flag; an event was dropped because the FIFO was full.
REQ-014 SEQ_ERR  output  1  one-cycle pulse when a prefix sequence is abandoned.

Function
REQ-015 A byte SHALL be accepted on a rising CLOCK edge where DATA_VALID=1 and the registered previous DATA_VALID=0; exactly one acceptance per high level.
REQ-016 Decoder states: IDLE, EXT, BRK, EXT_BRK.
REQ-017 IDLE: E0 -> EXT; F0 -> BRK; any other byte -> push {ext=0,brk=0,code}, stay IDLE.
REQ-018 EXT: F0 -> EXT_BRK; E0 -> stay EXT; other -> push {1,0,code} -> IDLE.
REQ-019 BRK: any byte -> push {0,1,code} -> IDLE.
REQ-020 EXT_BRK: any byte -> push {1,1,code} -> IDLE.
REQ-021 Pushed event SHALL appear at the outputs on the edge that accepts its byte when the FIFO was empty (KEY_VALID high in the following cycle).
REQ-022 FIFO is first-word-fall-through; pop on a rising edge where KEY_VALID=1 and KEY_READY=1.
REQ-023 Push while full without pop: event dropped, contents unchanged, OVERFLOW set to 1.
REQ-024 Simultaneous push and pop while full: both occur, LEVEL unchanged, OVERFLOW not set.
REQ-025 Simultaneous push and pop while empty: push only takes effect; KEY_READY with KEY_VALID=0 is ignored.
REQ-026 Read/write pointers wrap modulo 2**FIFO_AW; LEVEL ranges 0..2**FIFO_AW.
REQ-027 KEY_CODE/KEY_EXT/KEY_BREAK are undefined-but-stable when KEY_VALID=0; the bench SHALL NOT check them then.

Reset
REQ-028 RESET=1 SHALL immediately force state IDLE, FIFO empty, LEVEL=0, KEY_VALID=0, OVERFLOW=0, SEQ_ERR=0, KEY_CODE=0, KEY_EXT=0, KEY_BREAK=0, timeout counter 0.
REQ-029 Registered previous DATA_VALID SHALL reset to 1, so a level held high across reset release is not accepted.
REQ-030 Reset mid-prefix (e.g. after E0) SHALL discard the prefix; the next byte decodes from IDLE.

Configuration
REQ-031 Macro PS2_SCAN_TIMEOUT_EN: when defined, a counter clears on every accepted byte and increments each cycle in EXT, BRK or EXT_BRK; on reaching TIMEOUT_CYC-1 the decoder returns to IDLE and SEQ_ERR pulses for one cycle; nothing is pushed.
REQ-032 When PS2_SCAN_TIMEOUT_EN is undefined: no counter, prefix states wait indefinitely, SEQ_ERR tied to 0.

Verification
REQ-033 Bytes 1C -> event {code=1C, ext=0, brk=0}, KEY_VALID high the cycle after acceptance, LEVEL=1.
REQ-034 Bytes E0,F0,75 with KEY_READY=0 -> single event {75,1,1}; LEVEL=1; F0,1C -> {1C,0,1}.
REQ-035 With FIFO_AW=2 and KEY_READY=0, push 5 codes 01..05 -> LEVEL=4, OVERFLOW=1, drain yields 01,02,03,04.
REQ-036 DATA_VALID held high 20 cycles with RX_DATA=2A -> exactly one event; DATA_VALID high through reset release -> no event.
REQ-037 PS2_SCAN_TIMEOUT_EN, TIMEOUT_CYC=16: E0 then idle 16 cycles -> one SEQ_ERR pulse; next byte 1C -> {1C,0,0}.
REQ-038 Full FIFO, push 06 with KEY_READY=1 same edge -> LEVEL stays 4, OVERFLOW=0, 06 is last out.
